// File: rtl/alu_pkg.sv
// Shared opcode constants and pipeline register layouts for the ALU issue stage.
package alu_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_OR        = 5'd0;
   localparam logic [OP_W-1:0] OP_AND       = 5'd1;
   localparam logic [OP_W-1:0] OP_ADD       = 5'd2;
   localparam logic [OP_W-1:0] OP_MAX_LEGAL = 5'd2;

   // Destination tags are parameter-sized, so they live beside these structs.
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [31:0]     a;
      logic [31:0]     b;
   } y_reg_t;

   typedef struct packed {
      logic [31:0] z;
      logic        illegal;
   } z_reg_t;

endpackage

// File: rtl/alu_issue_stage.sv
// Two-register issue stage around an external combinational ALU.
// Optional ALU_FLAGS_EN adds registered out_zero / out_neg result flags.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEST_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic [DEST_W-1:0] in_dest,
   output logic [0:31]       alu_a,
   output logic [0:31]       alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [0:31]       alu_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_z,
   output logic [DEST_W-1:0] out_dest,
   output logic              out_illegal,
   output logic [CNT_W-1:0]  op_count
`ifdef ALU_FLAGS_EN
   ,
   output logic              out_zero,
   output logic              out_neg
`endif
);

   y_reg_t              y_q;
   logic [DEST_W-1:0]   y_dest_q;
   logic                v1_q;

   z_reg_t              z_q;
   logic [DEST_W-1:0]   z_dest_q;
   logic                v2_q;

   logic [CNT_W-1:0]    cnt_q;

   logic advance;
   logic accept;
   logic handshake;

   assign advance   = v1_q & (~v2_q | out_ready);
   assign in_ready  = ~v1_q | advance;
   assign accept    = in_valid & in_ready;
   assign handshake = v2_q & out_ready;

   assign alu_a  = v1_q ? y_q.a  : '0;
   assign alu_b  = v1_q ? y_q.b  : '0;
   assign alu_op = v1_q ? y_q.op : '0;

   assign out_valid   = v2_q;
   assign out_z       = z_q.z;
   assign out_dest    = z_dest_q;
   assign out_illegal = z_q.illegal;
   assign op_count    = cnt_q;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         y_q      <= '0;
         y_dest_q <= '0;
         v1_q     <= 1'b0;
      end else if (accept) begin
         y_q.op   <= in_op;
         y_q.a    <= in_a;
         y_q.b    <= in_b;
         y_dest_q <= in_dest;
         v1_q     <= 1'b1;
      end else if (advance) begin
         v1_q     <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         z_q      <= '0;
         z_dest_q <= '0;
         v2_q     <= 1'b0;
      end else if (advance) begin
         z_q.z       <= alu_c;
         z_q.illegal <= (y_q.op > OP_MAX_LEGAL);
         z_dest_q    <= y_dest_q;
         v2_q        <= 1'b1;
      end else if (handshake) begin
         v2_q        <= 1'b0;
      end
   end

   // Saturating: once all-ones the count stops rather than wrapping.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else if (handshake && !(&cnt_q)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef ALU_FLAGS_EN
   logic zero_q;
   logic neg_q;

   // alu_c is [0:31], so bit 0 is the sign bit.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (advance) begin
         zero_q <= (alu_c == '0);
         neg_q  <= alu_c[0];
      end
   end

   assign out_zero = zero_q;
   assign out_neg  = neg_q;
`endif

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter DEST_W, default 4, meaning the width of the destination-register tag.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the completed-operation counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port clr_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an upstream operation is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage accepts the offered operation this cycle.
REQ-007 SHALL have port in_op, input, 5 bits: the ALU operation code.
REQ-008 SHALL have ports in_a and in_b, input, 32 bits each: the operands.
REQ-009 SHALL have port in_dest, input, DEST_W bits: the destination tag, carried through with the operation.
REQ-010 SHALL have ports alu_a and alu_b, output, [0:31]: operands to the ALU; bit 0 is the MSB.
REQ-011 SHALL have port alu_op, output, 5 bits: the operation code to the ALU.
REQ-012 SHALL have port alu_c, input, [0:31]: the combinational ALU result.
REQ-013 SHALL have port out_valid, output, 1 bit: a result is available downstream.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port out_z, output, 32 bits: the result, held in the Z register.
REQ-016 SHALL have port out_dest, output, DEST_W bits: the destination tag of the result.
REQ-017 SHALL have port out_illegal, output, 1 bit: the result came from an opcode greater than 2.
REQ-018 SHALL have port op_count, output, CNT_W bits: the number of completed operations.

Function
REQ-019 SHALL implement two pipeline registers: Y (op, a, b, dest, valid v1) and Z (result, dest, illegal, valid v2).
REQ-020 SHALL drive alu_a, alu_b and alu_op combinationally from Y, and SHALL drive them to zero when v1=0.
REQ-021 SHALL define advance = v1 & (~v2 | out_ready), and in_ready = ~v1 | advance.
REQ-022 SHALL load Y from the in_* ports and set v1 on in_valid & in_ready; otherwise, on advance, SHALL clear v1.
REQ-023 SHALL, on advance, capture alu_c into Z, copy dest, set illegal = (op > 2), and set v2.
REQ-024 SHALL clear v2 on out_valid & out_ready when there is no advance in the same cycle.
REQ-025 Latency SHALL be: operation accepted in cycle N, out_valid=1 in cycle N+2 when there is no backpressure.
REQ-026 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-027 SHALL hold out_z, out_dest and out_illegal stable while out_valid=1 and out_ready=0.
REQ-028 SHALL hold Y contents unchanged while v1=1 and advance=0.
REQ-029 op_count SHALL increment on each out_valid & out_ready handshake and saturate at all-ones (no wrap).
REQ-030 Simultaneous accept and advance SHALL replace Y in the same edge with no bubble.
REQ-031 in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-032 On clk edge with clr_n=0, SHALL clear v1, v2, all Y and Z contents, and op_count.
REQ-033 During and after reset, in_ready SHALL be 1 and out_valid, out_z, out_dest, out_illegal SHALL be 0.
REQ-034 Reset mid-operation SHALL discard in-flight operations without counting them.

Configuration
REQ-035 With ALU_FLAGS_EN defined, SHALL add output ports out_zero (out_z == 0) and out_neg (MSB of out_z); both are registered with Z and cleared on reset.
REQ-036 Without ALU_FLAGS_EN, those ports and their logic SHALL be absent.

Structure
REQ-037 Shared package alu_pkg SHALL hold the opcode constants (OP_OR=0, OP_AND=1, OP_ADD=2), OP_MAX_LEGAL=2, and the Y and Z register struct typedefs.
REQ-038 SHALL contain no sub-modules; the ALU is instantiated alongside this block, not inside it.

Verification
REQ-039 Reset: clr_n=0 for 2 cycles, then 1 -> in_ready=1, out_valid=0, op_count=0.
REQ-040 Single add: op=2, a=5, b=7, dest=3 accepted in cycle N -> out_valid=1 in N+2 with out_z=12, out_dest=3; after the handshake, op_count=1.
REQ-041 Back-to-back: ops OR(0xF0,0x0F), AND(0xFF,0x3C), ADD(1,1) in consecutive cycles with out_ready=1 -> results 0xFF, 0x3C, 2 in consecutive cycles.
REQ-042 Backpressure: out_ready=0 while 3 ops are offered -> 2 accepted, then in_ready=0 and out_z held; release -> results in order, none lost.
REQ-043 Illegal op: op=7, a=0xF0F0, b=0xFF00 -> out_z=0xF000 (AND default) and out_illegal=1; op_count saturation: preload to 0xFFFF plus one handshake -> stays at 0xFFFF.
REQ-044 Flags (ALU_FLAGS_EN): ADD(0xFFFFFFFF,1) -> out_zero=1, out_neg=0; OR(0x80000000,0) -> out_neg=1.
